// File: rtl/axil2reg_rd.sv
// AXI4-Lite read-channel slave: turns an AR beat into a one-cycle register-file read
// strobe, waits a fixed latency for the data, then holds the R beat until accepted.
module axil2reg_rd #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]            s_axil_arprot,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic [ADDR_WIDTH-1:0] reg_rd_addr,
   output logic                  reg_rd_en,
   input  logic [DATA_WIDTH-1:0] reg_rd_data,
   input  logic                  reg_rd_okay
);

   localparam logic [3:0] CntInit = 4'(RD_LATENCY - 1);
   localparam logic [1:0] RespOkay = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   // Protection bits carry no meaning for a CSR file.
   logic unused_prot;
   assign unused_prot = ^s_axil_arprot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         rresp_q <= RespOkay;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      rresp_d = rresp_q;
      unique case (state_q)
         StIdle: begin
            if (s_axil_arvalid) begin
               state_d = StWait;
               cnt_d   = CntInit;
            end
         end
         StWait: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = StResp;
               // Register data is dropped on a decode error so nothing leaks out.
               if (reg_rd_okay) begin
                  rdata_d = reg_rd_data;
                  rresp_d = RespOkay;
               end else begin
                  rdata_d = '0;
                  rresp_d = RespSlvErr;
               end
            end
         end
         StResp: begin
            if (s_axil_rready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign s_axil_arready = (state_q == StIdle);
   assign reg_rd_en      = (state_q == StIdle) && s_axil_arvalid;
   assign reg_rd_addr    = s_axil_araddr;
   assign s_axil_rvalid  = (state_q == StResp);
   assign s_axil_rdata   = rdata_q;
   assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_axil2reg_rd.sv
// Directed-vector and scoreboard bench for axil2reg_rd at read latencies 1 and 3.
module tb_axil2reg_rd;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   // Latency-1 instance, register file driven directly by the bench.
   logic [31:0] araddr1 = '0;
   logic [2:0]  arprot1 = '0;
   logic        arvalid1 = 1'b0, arready1, rvalid1, rready1 = 1'b1, rd_en1, okay1 = 1'b1;
   logic [31:0] rdata1, rd_addr1, rd_data1 = '0;
   logic [1:0]  rresp1;

   axil2reg_rd #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .s_axil_araddr(araddr1), .s_axil_arprot(arprot1), .s_axil_arvalid(arvalid1),
      .s_axil_arready(arready1), .s_axil_rdata(rdata1), .s_axil_rresp(rresp1),
      .s_axil_rvalid(rvalid1), .s_axil_rready(rready1),
      .reg_rd_addr(rd_addr1), .reg_rd_en(rd_en1), .reg_rd_data(rd_data1),
      .reg_rd_okay(okay1)
   );

   // Latency-3 instance; data is tagged with the cycle it was presented in.
   logic [31:0] araddr3 = '0;
   logic [2:0]  arprot3 = '0;
   logic        arvalid3 = 1'b0, arready3, rvalid3, rready3 = 1'b1, rd_en3, okay3;
   logic [31:0] rdata3, rd_addr3, rd_data3;
   logic [1:0]  rresp3;
   logic        okay_mode = 1'b0;

   assign rd_data3 = {16'hA53C, cyc[15:0]};
   assign okay3    = okay_mode ? (cyc % 5 != 0) : 1'b1;

   axil2reg_rd #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3)) u3 (
      .clk(clk), .rst_n(rst_n),
      .s_axil_araddr(araddr3), .s_axil_arprot(arprot3), .s_axil_arvalid(arvalid3),
      .s_axil_arready(arready3), .s_axil_rdata(rdata3), .s_axil_rresp(rresp3),
      .s_axil_rvalid(rvalid3), .s_axil_rready(rready3),
      .reg_rd_addr(rd_addr3), .reg_rd_en(rd_en3), .reg_rd_data(rd_data3),
      .reg_rd_okay(okay3)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        ok;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_rresp;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   initial begin
      int strobes[$];
      int nbeats;
      int exp_t[$];
      logic        prev_stall;
      logic [31:0] prev_data;
      logic [1:0]  prev_resp;

      vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 2'b00};
      vecs[1] = '{32'h0000_0FFC, 32'h1234_5678, 1'b0, 32'h0000_0000, 2'b10};
      vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 2'b00};
      vecs[3] = '{32'h7FFF_FFFC, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 2'b00};
      vecs[4] = '{32'h0000_0020, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 2'b10};

      // Reset state
      #12;
      chk("rst_rvalid", 32'(rvalid1), 32'd0);
      chk("rst_arready", 32'(arready1), 32'd1);
      chk("rst_rdata", rdata1, 32'd0);
      chk("rst_rresp", 32'(rresp1), 32'd0);
      chk("rst_rd_en", 32'(rd_en1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven single reads, latency 1, rready held high
      foreach (vecs[i]) begin
         step();
         arvalid1 = 1'b1; araddr1 = vecs[i].addr; arprot1 = 3'($urandom);
         rready1 = 1'b1; rd_data1 = ~vecs[i].data; okay1 = ~vecs[i].ok;
         @(negedge clk);
         chk("v_arready_T", 32'(arready1), 32'd1);
         chk("v_rd_en_T", 32'(rd_en1), 32'd1);
         chk("v_rd_addr_T", rd_addr1, vecs[i].addr);
         chk("v_rvalid_T", 32'(rvalid1), 32'd0);
         step();
         arvalid1 = 1'b0; araddr1 = 32'hBAD0; rd_data1 = vecs[i].data; okay1 = vecs[i].ok;
         @(negedge clk);
         chk("v_arready_T1", 32'(arready1), 32'd0);
         chk("v_rd_en_T1", 32'(rd_en1), 32'd0);
         chk("v_rvalid_T1", 32'(rvalid1), 32'd0);
         step();
         rd_data1 = ~vecs[i].data; okay1 = ~vecs[i].ok;
         @(negedge clk);
         chk("v_rvalid_T2", 32'(rvalid1), 32'd1);
         chk("v_rdata_T2", rdata1, vecs[i].exp_rdata);
         chk("v_rresp_T2", 32'(rresp1), 32'(vecs[i].exp_rresp));
         chk("v_arready_T2", 32'(arready1), 32'd0);
         step();
         @(negedge clk);
         chk("v_rvalid_T3", 32'(rvalid1), 32'd0);
         chk("v_arready_T3", 32'(arready1), 32'd1);
      end

      // Backpressure with a second request pending
      step();
      arvalid1 = 1'b1; araddr1 = 32'h40; rd_data1 = 32'h0BAD_0BAD; okay1 = 1'b0;
      @(negedge clk);
      chk("bp_rd_en_first", 32'(rd_en1), 32'd1);
      step();
      araddr1 = 32'h44; rd_data1 = 32'h1111_2222; okay1 = 1'b1; rready1 = 1'b0;
      @(negedge clk);
      chk("bp_rd_en_wait", 32'(rd_en1), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         rd_data1 = 32'h5000 + 32'(i); okay1 = i[0];
         @(negedge clk);
         chk("bp_rvalid", 32'(rvalid1), 32'd1);
         chk("bp_rdata", rdata1, 32'h1111_2222);
         chk("bp_rresp", 32'(rresp1), 32'd0);
         chk("bp_arready", 32'(arready1), 32'd0);
         chk("bp_rd_en", 32'(rd_en1), 32'd0);
      end
      step();
      rready1 = 1'b1;
      @(negedge clk);
      chk("bp_rvalid_accept", 32'(rvalid1), 32'd1);
      chk("bp_arready_accept", 32'(arready1), 32'd0);
      chk("bp_rd_en_accept", 32'(rd_en1), 32'd0);
      step();
      @(negedge clk);
      chk("bp_rvalid_after", 32'(rvalid1), 32'd0);
      chk("bp_arready_after", 32'(arready1), 32'd1);
      chk("bp_rd_en_second", 32'(rd_en1), 32'd1);
      chk("bp_rd_addr_second", rd_addr1, 32'h44);
      step();
      arvalid1 = 1'b0; rd_data1 = 32'h3333_4444; okay1 = 1'b1;
      step();
      rd_data1 = 32'h0;
      @(negedge clk);
      chk("bp_second_rvalid", 32'(rvalid1), 32'd1);
      chk("bp_second_rdata", rdata1, 32'h3333_4444);
      step();

      // Reset during WAIT
      arvalid1 = 1'b1; araddr1 = 32'h8;
      step();
      arvalid1 = 1'b0; rd_data1 = 32'h7777_7777; okay1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rw_rvalid", 32'(rvalid1), 32'd0);
      chk("rw_rdata", rdata1, 32'd0);
      chk("rw_rresp", 32'(rresp1), 32'd0);
      chk("rw_arready", 32'(arready1), 32'd1);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rw_no_beat", 32'(rvalid1), 32'd0);
         chk("rw_idle", 32'(arready1), 32'd1);
      end

      // Reset during RESP under backpressure
      step();
      arvalid1 = 1'b1; araddr1 = 32'hC; rready1 = 1'b0;
      step();
      arvalid1 = 1'b0; rd_data1 = 32'hCAFE_F00D; okay1 = 1'b0;
      step();
      @(negedge clk);
      chk("rr_rvalid_pre", 32'(rvalid1), 32'd1);
      chk("rr_rresp_pre", 32'(rresp1), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rr_rvalid", 32'(rvalid1), 32'd0);
      chk("rr_rdata", rdata1, 32'd0);
      chk("rr_rresp", 32'(rresp1), 32'd0);
      step();
      rst_n = 1'b1; rready1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rr_no_beat", 32'(rvalid1), 32'd0);
         chk("rr_idle", 32'(arready1), 32'd1);
      end

      // Latency 3, back-to-back reads with arvalid held high
      step();
      okay_mode = 1'b0; arvalid3 = 1'b1; araddr3 = 32'h0; rready3 = 1'b1;
      nbeats = 0;
      for (int c = 0; c < 40 && nbeats < 2; c++) begin
         @(negedge clk);
         if (rd_en3) begin
            chk("l3_addr", rd_addr3, (strobes.size() == 0) ? 32'h0 : 32'h4);
            if (strobes.size() > 0) chk("l3_spacing", 32'(cyc - strobes[0]), 32'd5);
            strobes.push_back(cyc);
         end
         if (rvalid3) begin
            chk("l3_beat_has_strobe", 32'(nbeats < strobes.size()), 32'd1);
            if (nbeats < strobes.size()) begin
               chk("l3_rdata", rdata3, {16'hA53C, 16'(strobes[nbeats] + 3)});
               chk("l3_rvalid_latency", 32'(cyc - strobes[nbeats]), 32'd4);
            end
            nbeats++;
         end
         step();
         if (strobes.size() == 1) araddr3 = 32'h4;
         if (strobes.size() >= 2) arvalid3 = 1'b0;
      end
      chk("l3_beats", 32'(nbeats), 32'd2);
      chk("l3_strobes", 32'(strobes.size()), 32'd2);

      // Random stress against a cycle-tagged register-file model
      okay_mode  = 1'b1;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_resp  = '0;
      for (int i = 0; i < 410; i++) begin
         step();
         arvalid3 = (i < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
         rready3  = (i < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
         araddr3  = $urandom;
         arprot3  = 3'($urandom);
         @(negedge clk);
         chk("st_strobe", 32'(rd_en3), 32'(arvalid3 && arready3));
         if (rd_en3) begin
            chk("st_rd_addr", rd_addr3, araddr3);
            exp_t.push_back(cyc);
         end
         if (prev_stall) begin
            chk("st_hold_rvalid", 32'(rvalid3), 32'd1);
            chk("st_hold_rdata", rdata3, prev_data);
            chk("st_hold_rresp", 32'(rresp3), 32'(prev_resp));
         end
         if (rvalid3 && rready3) begin
            chk("st_beat_pending", 32'(exp_t.size() > 0), 32'd1);
            if (exp_t.size() > 0) begin
               int c;
               logic ok;
               c  = exp_t.pop_front() + 3;
               ok = (c % 5 != 0);
               chk("st_rdata", rdata3, ok ? {16'hA53C, 16'(c)} : 32'h0);
               chk("st_rresp", 32'(rresp3), ok ? 32'd0 : 32'd2);
            end
         end
         prev_stall = rvalid3 && !rready3;
         prev_data  = rdata3;
         prev_resp  = rresp3;
      end
      chk("st_all_beats_returned", 32'(exp_t.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axil2reg_rd.md
Name: axil2reg_rd

Overview:
AXI4-Lite read-channel slave (AR/R) that converts AXI-Lite read transactions into a simple register-file read strobe. It is the read-side counterpart of the AXI-Lite write bridge and sits between an AXI-Lite interconnect port and a block's CSR file. The register file returns data and a status flag a fixed number of cycles after the strobe. The bridge captures that data and holds the R beat until the master accepts it.

Parameters:
ADDR_WIDTH, 32, width of araddr and reg_rd_addr
DATA_WIDTH, 32, width of rdata and reg_rd_data
RD_LATENCY, 1, cycles from reg_rd_en to valid reg_rd_data/reg_rd_okay; legal range 1..15

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arprot  in  3  protection bits; accepted, ignored
s_axil_arvalid  in  1  AR valid
s_axil_arready  out  1  AR ready
s_axil_rdata  out  DATA_WIDTH  read data
s_axil_rresp  out  2  00 OKAY, 10 SLVERR
s_axil_rvalid  out  1  R valid
s_axil_rready  in  1  R ready
reg_rd_addr  out  ADDR_WIDTH  register address; meaningful only while reg_rd_en=1
reg_rd_en  out  1  one-cycle read strobe
reg_rd_data  in  DATA_WIDTH  register data, valid RD_LATENCY cycles after reg_rd_en
reg_rd_okay  in  1  1 = address decoded OK; sampled together with reg_rd_data

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low. All flops reset asynchronously.
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- Reset values: state=IDLE, cnt=0, s_axil_rvalid=0, s_axil_rdata=0, s_axil_rresp=00.
- Combinational outputs:
  - s_axil_arready = (state==IDLE).
  - reg_rd_en = (state==IDLE) && s_axil_arvalid.
  - reg_rd_addr = s_axil_araddr, a pass-through with no register.
- AR handshake: happens in the cycle where IDLE && arvalid (cycle T).
  - reg_rd_en=1 in cycle T only.
  - Next state is WAIT, with cnt loaded to RD_LATENCY-1.
- WAIT:
  - If cnt!=0: decrement cnt.
  - If cnt==0 (cycle T+RD_LATENCY): sample reg_rd_okay and reg_rd_data, then go to RESP.
  - On capture with reg_rd_okay=1: rdata<=reg_rd_data, rresp<=00.
  - On capture with reg_rd_okay=0: rdata<=0, rresp<=10. Register data is discarded on error.
- RESP:
  - s_axil_rvalid=1 (registered; first high in cycle T+RD_LATENCY+1).
  - rdata and rresp stay stable while rvalid && !rready.
  - On rready: go to IDLE, rvalid<=0.
- Latency and throughput:
  - AR handshake to rvalid is RD_LATENCY+1 cycles.
  - rready is honoured in the first rvalid cycle.
  - arready reasserts the cycle after the R handshake.
  - Maximum throughput is one read per RD_LATENCY+2 cycles.
- Single outstanding read:
  - arready=0 in WAIT and RESP.
  - arvalid/araddr changes during WAIT/RESP have no effect.
  - reg_rd_en never asserts outside IDLE.
- Input timing: reg_rd_data and reg_rd_okay are ignored in every cycle other than the capture cycle.
- Counter: width 4 bits. RD_LATENCY=1 gives cnt=0 on entry, so capture happens in the first WAIT cycle.
- rready while rvalid=0 has no effect.
- Reset mid-operation: the transaction is abandoned and rvalid drops immediately (asynchronously). After reset release the bridge is IDLE with arready=1 and issues no R beat for the abandoned read.
- arprot is not decoded.
- SLVERR is generated only from reg_rd_okay=0.

Test Plan:
- Single read, RD_LATENCY=1, araddr=0x10, reg returns 0xDEADBEEF okay=1, rready held 1 -> reg_rd_en one cycle at T with reg_rd_addr=0x10; rvalid at T+2 with rdata=0xDEADBEEF, rresp=00; arready=1 at T+3.
- Error read, araddr=0xFFC, okay=0, reg_rd_data=0x12345678 -> rresp=10, rdata=0x00000000.
- Backpressure: rready=0 for 5 cycles after rvalid, reg_rd_data changes every cycle -> rdata/rresp constant; rvalid held; arvalid of a second request not accepted (arready=0, no reg_rd_en) until the cycle after rready=1.
- RD_LATENCY=3, back-to-back reads 0x0 then 0x4 with arvalid continuously high and rready=1 -> reg_rd_en pulses spaced 5 cycles apart; each rdata equals the value presented exactly 3 cycles after its strobe, not a value presented at 2 or 4 cycles.
- Reset mid-operation: assert rst_n=0 during WAIT and again during RESP -> rvalid=0 immediately, rdata=0, rresp=00; after release arready=1 and no spurious R beat.
- Random stress: random arvalid/rready toggling against a scoreboard model of the register file -> every R beat matches the model, exactly one reg_rd_en per AR handshake, and no AXI stability violations (rdata/rresp/rvalid held under backpressure).
